dbus_interconnect: RTL and testbench

- Parametrised data-bus interconnect between the CPU data port and N slaves (memory, iosystem instances, future peripherals).
- Replaces the two-way fixed-split decode with a region table of N entries, mapped or unmapped.
- Adds variable-latency slave reads with a master stall, bus-error signalling for unmapped accesses, and an optional read timeout.

---
 rtl/dbus_pkg.sv | 43 ++++
 rtl/dbus_decode.sv | 33 +++
 rtl/dbus_interconnect.sv | 169 ++++++++++++++++
 tb/tb_dbus_interconnect.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus interconnect: default region map,
// read FSM state type and the region decode helper.
package dbus_pkg;

  localparam int MAX_SLAVES = 8;
  localparam int MAX_ADDRW  = 32;
  localparam int IDX_W      = 3;

  localparam int DEF_NSLAVES = 4;
  localparam int DEF_ADDRW   = 16;

  localparam logic [63:0] DEF_REGION_BASE  = {16'h8000, 16'h2000, 16'h0100, 16'h0000};
  localparam logic [63:0] DEF_REGION_LIMIT = {16'hFFFF, 16'h7FFF, 16'h01FF, 16'h00FF};

  typedef enum logic {
    DBUS_IDLE = 1'b0,
    DBUS_WAIT = 1'b1
  } dbus_state_t;

  // Returns {hit, index}. Regions are scanned from the top down so that the
  // lowest matching index is the one left standing when regions overlap.
  function automatic logic [IDX_W:0] region_decode(
    input logic [MAX_ADDRW-1:0]            addr,
    input logic [MAX_SLAVES*MAX_ADDRW-1:0] base,
    input logic [MAX_SLAVES*MAX_ADDRW-1:0] limit,
    input int                              nslaves
  );
    logic             hit;
    logic [IDX_W-1:0] idx;
    hit = 1'b0;
    idx = '0;
    for (int k = MAX_SLAVES - 1; k >= 0; k--) begin
      if ((k < nslaves) &&
          (addr >= base[k*MAX_ADDRW +: MAX_ADDRW]) &&
          (addr <= limit[k*MAX_ADDRW +: MAX_ADDRW])) begin
        hit = 1'b1;
        idx = IDX_W'(k);
      end
    end
    return {hit, idx};
  endfunction

endpackage

// File: rtl/dbus_decode.sv
// Combinational region matcher: maps an address onto the slave whose
// inclusive [base, limit] window contains it, lowest index first.
module dbus_decode
  import dbus_pkg::*;
#(
  parameter int                         NSLAVES      = DEF_NSLAVES,
  parameter int                         ADDRW        = DEF_ADDRW,
  parameter logic [NSLAVES*ADDRW-1:0]   REGION_BASE  = DEF_REGION_BASE,
  parameter logic [NSLAVES*ADDRW-1:0]   REGION_LIMIT = DEF_REGION_LIMIT
) (
  input  logic [ADDRW-1:0] addr,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  logic [MAX_SLAVES*MAX_ADDRW-1:0] base_w;
  logic [MAX_SLAVES*MAX_ADDRW-1:0] limit_w;
  logic [IDX_W:0]                  result;

  // Widen the region table to the helper's fixed layout and decode.
  always_comb begin
    base_w  = '0;
    limit_w = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      base_w[k*MAX_ADDRW +: MAX_ADDRW]  = MAX_ADDRW'(REGION_BASE[k*ADDRW +: ADDRW]);
      limit_w[k*MAX_ADDRW +: MAX_ADDRW] = MAX_ADDRW'(REGION_LIMIT[k*ADDRW +: ADDRW]);
    end
    result = region_decode(MAX_ADDRW'(addr), base_w, limit_w, NSLAVES);
    hit    = result[IDX_W];
    index  = result[IDX_W-1:0];
  end

endmodule

// File: rtl/dbus_interconnect.sv
// Data-bus interconnect between the CPU data port and NSLAVES slaves.
// Writes are posted combinationally; reads run through an IDLE/WAIT FSM
// that stalls the master until the selected slave responds. Unmapped
// accesses return a one-cycle bus_error pulse.
// Optional: define DBUS_TIMEOUT_EN to bound each read wait to
// TIMEOUT_CYCLES cycles, after which the read ends with a bus error.
module dbus_interconnect
  import dbus_pkg::*;
#(
  parameter int                       NSLAVES        = DEF_NSLAVES,
  parameter int                       ADDRW          = DEF_ADDRW,
  parameter int                       DATAW          = 16,
  parameter logic [NSLAVES*ADDRW-1:0] REGION_BASE    = DEF_REGION_BASE,
  parameter logic [NSLAVES*ADDRW-1:0] REGION_LIMIT   = DEF_REGION_LIMIT,
  parameter int                       TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDRW-1:0]              m_read_addr,
  input  logic                          m_read_req,
  output logic [DATAW-1:0]              m_read_data,
  output logic                          m_read_valid,
  output logic                          m_stall,
  input  logic [ADDRW-1:0]              m_write_addr,
  input  logic [DATAW-1:0]              m_write_data,
  input  logic [DATAW/8-1:0]            m_write_en,
  output logic                          bus_error,
  output logic [ADDRW-1:0]              s_read_addr,
  output logic [NSLAVES-1:0]            s_read_req,
  input  logic [NSLAVES*DATAW-1:0]      s_read_data,
  input  logic [NSLAVES-1:0]            s_read_valid,
  output logic [ADDRW-1:0]              s_write_addr,
  output logic [DATAW-1:0]              s_write_data,
  output logic [NSLAVES*(DATAW/8)-1:0]  s_write_en
);

  localparam int BE = DATAW / 8;

  if ((NSLAVES < 1) || (NSLAVES > MAX_SLAVES) || ((DATAW % 8) != 0) ||
      (ADDRW > MAX_ADDRW) || (TIMEOUT_CYCLES < 1)) begin : g_bad_params
    $error("dbus_interconnect: unsupported parameter combination");
  end

  dbus_state_t      state;
  logic [IDX_W-1:0] sel;
  logic             rd_err_q;
  logic             bus_error_q;

  logic             rd_hit;
  logic [IDX_W-1:0] rd_idx;
  logic             wr_hit;
  logic [IDX_W-1:0] wr_idx;

  logic             sel_valid;
  logic [DATAW-1:0] sel_data;
  logic             wait_done;
  logic             accept;
  logic             rd_unmapped;
  logic             wr_unmapped;
  logic             timeout_hit;

  dbus_decode #(
    .NSLAVES      (NSLAVES),
    .ADDRW        (ADDRW),
    .REGION_BASE  (REGION_BASE),
    .REGION_LIMIT (REGION_LIMIT)
  ) u_read_decode (
    .addr  (m_read_addr),
    .hit   (rd_hit),
    .index (rd_idx)
  );

  dbus_decode #(
    .NSLAVES      (NSLAVES),
    .ADDRW        (ADDRW),
    .REGION_BASE  (REGION_BASE),
    .REGION_LIMIT (REGION_LIMIT)
  ) u_write_decode (
    .addr  (m_write_addr),
    .hit   (wr_hit),
    .index (wr_idx)
  );

  // Pick the response lines of the slave that owns the outstanding read.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (sel == IDX_W'(k)) begin
        sel_valid = s_read_valid[k];
        sel_data  = s_read_data[k*DATAW +: DATAW];
      end
    end
  end

  assign wait_done   = (state == DBUS_WAIT) && sel_valid;
  assign accept      = m_read_req && ((state == DBUS_IDLE) || wait_done);
  assign rd_unmapped = accept && !rd_hit;
  assign wr_unmapped = !wr_hit && (|m_write_en);

  assign m_stall      = (state == DBUS_WAIT) && !wait_done;
  assign m_read_valid = wait_done || rd_err_q;
  assign m_read_data  = wait_done ? sel_data : '0;
  assign bus_error    = bus_error_q;

  assign s_read_addr  = m_read_addr;
  assign s_write_addr = m_write_addr;
  assign s_write_data = m_write_data;

`ifdef DBUS_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNTW-1:0] wait_cnt;
  assign timeout_hit = (state == DBUS_WAIT) && !sel_valid &&
                       (wait_cnt == CNTW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // One-hot read strobe to the decoded slave whenever a read is accepted.
  always_comb begin
    s_read_req = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (accept && rd_hit && (rd_idx == IDX_W'(k))) begin
        s_read_req[k] = 1'b1;
      end
    end
  end

  // Route the master byte enables only to the slave owning the write address.
  always_comb begin
    s_write_en = '0;
    for (int k = 0; k < NSLAVES; k++) begin
      if (wr_hit && (wr_idx == IDX_W'(k))) begin
        s_write_en[k*BE +: BE] = m_write_en;
      end
    end
  end

  // Read FSM: tracks the outstanding slave and registers the error pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= DBUS_IDLE;
      sel         <= '0;
      rd_err_q    <= 1'b0;
      bus_error_q <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      rd_err_q    <= rd_unmapped || timeout_hit;
      bus_error_q <= rd_unmapped || wr_unmapped || timeout_hit;
`ifdef DBUS_TIMEOUT_EN
      if (state == DBUS_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
`endif
      if (accept && rd_hit) begin
        state <= DBUS_WAIT;
        sel   <= rd_idx;
`ifdef DBUS_TIMEOUT_EN
        wait_cnt <= '0;
`endif
      end else if (wait_done || timeout_hit) begin
        state <= DBUS_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_dbus_interconnect.sv
// Directed self-checking bench for dbus_interconnect (default 4-slave map).
// Covers the timeout path when built with DBUS_TIMEOUT_EN.
module tb_dbus_interconnect;

  logic        clk;
  logic        reset;
  logic [15:0] m_read_addr;
  logic        m_read_req;
  logic [15:0] m_read_data;
  logic        m_read_valid;
  logic        m_stall;
  logic [15:0] m_write_addr;
  logic [15:0] m_write_data;
  logic [1:0]  m_write_en;
  logic        bus_error;
  logic [15:0] s_read_addr;
  logic [3:0]  s_read_req;
  logic [63:0] s_read_data;
  logic [3:0]  s_read_valid;
  logic [15:0] s_write_addr;
  logic [15:0] s_write_data;
  logic [7:0]  s_write_en;

  int test_count = 0;
  int fail_count = 0;
  int n;

  dbus_interconnect dut (
    .clk          (clk),
    .reset        (reset),
    .m_read_addr  (m_read_addr),
    .m_read_req   (m_read_req),
    .m_read_data  (m_read_data),
    .m_read_valid (m_read_valid),
    .m_stall      (m_stall),
    .m_write_addr (m_write_addr),
    .m_write_data (m_write_data),
    .m_write_en   (m_write_en),
    .bus_error    (bus_error),
    .s_read_addr  (s_read_addr),
    .s_read_req   (s_read_req),
    .s_read_data  (s_read_data),
    .s_read_valid (s_read_valid),
    .s_write_addr (s_write_addr),
    .s_write_data (s_write_data),
    .s_write_en   (s_write_en)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic req, input logic [15:0] raddr,
                               input logic [1:0] wen, input logic [15:0] waddr,
                               input logic [3:0] svalid);
    @(negedge clk);
    m_read_req   = req;
    m_read_addr  = raddr;
    m_write_en   = wen;
    m_write_addr = waddr;
    s_read_valid = svalid;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset        = 1'b1;
    m_read_req   = 1'b0;
    m_read_addr  = '0;
    m_write_addr = '0;
    m_write_en   = '0;
    m_write_data = 16'h5A5A;
    s_read_valid = '0;
    s_read_data  = {16'hC3C3, 16'h1234, 16'hBEEF, 16'h0A0A};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_stall", 32'(m_stall), 32'd0);
    checkOutput("rst_valid", 32'(m_read_valid), 32'd0);
    checkOutput("rst_data", 32'(m_read_data), 32'd0);
    checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
    checkOutput("rst_s_read_req", 32'(s_read_req), 32'd0);
    checkOutput("rst_s_write_en", 32'(s_write_en), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Slave1 read, one wait cycle before the response
    applyStimulus(1'b1, 16'h0120, 2'b00, 16'h0000, 4'b0000);
    checkOutput("rd1_s_read_req", 32'(s_read_req), 32'h2);
    checkOutput("rd1_s_read_addr", 32'(s_read_addr), 32'h0120);
    checkOutput("rd1_req_stall", 32'(m_stall), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("rd1_wait_stall", 32'(m_stall), 32'd1);
    checkOutput("rd1_wait_valid", 32'(m_read_valid), 32'd0);
    checkOutput("rd1_wait_s_read_req", 32'(s_read_req), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0010);
    checkOutput("rd1_valid", 32'(m_read_valid), 32'd1);
    checkOutput("rd1_data", 32'(m_read_data), 32'hBEEF);
    checkOutput("rd1_resp_stall", 32'(m_stall), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("rd1_after_valid", 32'(m_read_valid), 32'd0);
    checkOutput("rd1_after_data", 32'(m_read_data), 32'd0);

    // Slave2 read with 5-cycle latency and a stray slave3 response
    applyStimulus(1'b1, 16'h3000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("rd2_s_read_req", 32'(s_read_req), 32'h4);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, (i == 2) ? 4'b1000 : 4'b0000);
      checkOutput("rd2_wait_stall", 32'(m_stall), 32'd1);
      checkOutput("rd2_wait_valid", 32'(m_read_valid), 32'd0);
    end
    // Response cycle also accepts a back-to-back read to slave0
    applyStimulus(1'b1, 16'h0050, 2'b00, 16'h0000, 4'b0100);
    checkOutput("rd2_valid", 32'(m_read_valid), 32'd1);
    checkOutput("rd2_data", 32'(m_read_data), 32'h1234);
    checkOutput("rd2_resp_stall", 32'(m_stall), 32'd0);
    checkOutput("b2b_s_read_req", 32'(s_read_req), 32'h1);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0001);
    checkOutput("b2b_valid", 32'(m_read_valid), 32'd1);
    checkOutput("b2b_data", 32'(m_read_data), 32'h0A0A);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("b2b_after_valid", 32'(m_read_valid), 32'd0);
    checkOutput("b2b_after_stall", 32'(m_stall), 32'd0);

    // Unmapped read
    applyStimulus(1'b1, 16'h1000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("unm_rd_s_read_req", 32'(s_read_req), 32'd0);
    checkOutput("unm_rd_req_valid", 32'(m_read_valid), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("unm_rd_valid", 32'(m_read_valid), 32'd1);
    checkOutput("unm_rd_data", 32'(m_read_data), 32'd0);
    checkOutput("unm_rd_bus_error", 32'(bus_error), 32'd1);
    checkOutput("unm_rd_stall", 32'(m_stall), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("unm_rd_err_clear", 32'(bus_error), 32'd0);
    checkOutput("unm_rd_valid_clear", 32'(m_read_valid), 32'd0);

    // Unmapped write
    applyStimulus(1'b0, 16'h0000, 2'b11, 16'h1000, 4'b0000);
    checkOutput("unm_wr_s_write_en", 32'(s_write_en), 32'd0);
    checkOutput("unm_wr_err_same", 32'(bus_error), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("unm_wr_bus_error", 32'(bus_error), 32'd1);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("unm_wr_err_clear", 32'(bus_error), 32'd0);

    // Simultaneous unmapped read and write give one pulse
    applyStimulus(1'b1, 16'h1000, 2'b11, 16'h1000, 4'b0000);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("both_unm_bus_error", 32'(bus_error), 32'd1);
    checkOutput("both_unm_valid", 32'(m_read_valid), 32'd1);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("both_unm_err_clear", 32'(bus_error), 32'd0);

    // Region boundaries: 0x01FF is slave1, 0x0200 is unmapped
    applyStimulus(1'b1, 16'h01FF, 2'b00, 16'h0000, 4'b0000);
    checkOutput("bnd_rd_s_read_req", 32'(s_read_req), 32'h2);
    applyStimulus(1'b0, 16'h0000, 2'b01, 16'h0200, 4'b0010);
    checkOutput("bnd_rd_data", 32'(m_read_data), 32'hBEEF);
    checkOutput("bnd_wr_s_write_en", 32'(s_write_en), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("bnd_wr_bus_error", 32'(bus_error), 32'd1);

    // Posted writes during an outstanding slave3 read
    applyStimulus(1'b1, 16'h9000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("rd3_s_read_req", 32'(s_read_req), 32'h8);
    applyStimulus(1'b0, 16'h0000, 2'b01, 16'h00FF, 4'b0000);
    checkOutput("wr0_s_write_en", 32'(s_write_en), 32'h01);
    checkOutput("wr0_s_write_addr", 32'(s_write_addr), 32'h00FF);
    checkOutput("wr0_s_write_data", 32'(s_write_data), 32'h5A5A);
    checkOutput("wr0_stall", 32'(m_stall), 32'd1);
    applyStimulus(1'b0, 16'h0000, 2'b11, 16'h0100, 4'b0000);
    checkOutput("wr1_s_write_en", 32'(s_write_en), 32'h0C);
    checkOutput("wr1_bus_error", 32'(bus_error), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b10, 16'h7FFF, 4'b1000);
    checkOutput("wr2_s_write_en", 32'(s_write_en), 32'h20);
    checkOutput("rd3_valid", 32'(m_read_valid), 32'd1);
    checkOutput("rd3_data", 32'(m_read_data), 32'hC3C3);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("rd3_no_error", 32'(bus_error), 32'd0);

    // Reset while waiting aborts the read; late response ignored
    applyStimulus(1'b1, 16'h3000, 2'b00, 16'h0000, 4'b0000);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("rstw_pre_stall", 32'(m_stall), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rstw_stall", 32'(m_stall), 32'd0);
    checkOutput("rstw_valid", 32'(m_read_valid), 32'd0);
    @(negedge clk);
    reset        = 1'b0;
    s_read_valid = 4'b0100;
    #1;
    checkOutput("rstw_late_valid", 32'(m_read_valid), 32'd0);
    checkOutput("rstw_late_data", 32'(m_read_data), 32'd0);
    checkOutput("rstw_late_stall", 32'(m_stall), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    checkOutput("rstw_idle_valid", 32'(m_read_valid), 32'd0);
    checkOutput("rstw_idle_bus_error", 32'(bus_error), 32'd0);

`ifdef DBUS_TIMEOUT_EN
    // Silent slave: read ends after exactly 64 wait cycles with an error
    applyStimulus(1'b1, 16'h3000, 2'b00, 16'h0000, 4'b0000);
    n = 0;
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    while (m_stall && (n < 200)) begin
      n++;
      applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    end
    checkOutput("to_wait_cycles", 32'(n), 32'd64);
    checkOutput("to_valid", 32'(m_read_valid), 32'd1);
    checkOutput("to_data", 32'(m_read_data), 32'd0);
    checkOutput("to_bus_error", 32'(bus_error), 32'd1);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0100);
    checkOutput("to_after_valid", 32'(m_read_valid), 32'd0);
    checkOutput("to_after_stall", 32'(m_stall), 32'd0);
`else
    // Without a timeout the read waits as long as the slave takes
    applyStimulus(1'b1, 16'h3000, 2'b00, 16'h0000, 4'b0000);
    n = 0;
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    while (m_stall && (n < 100)) begin
      n++;
      if (n < 100) applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0000);
    end
    checkOutput("long_wait_cycles", 32'(n), 32'd100);
    checkOutput("long_wait_stall", 32'(m_stall), 32'd1);
    checkOutput("long_wait_bus_error", 32'(bus_error), 32'd0);
    applyStimulus(1'b0, 16'h0000, 2'b00, 16'h0000, 4'b0100);
    checkOutput("long_valid", 32'(m_read_valid), 32'd1);
    checkOutput("long_data", 32'(m_read_data), 32'h1234);
`endif

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
